// File: rtl/rotabit_checker.sv
`default_nettype none
// ============================================================================
// Module      : rotabit_checker
// Description : Locks onto a rotating one-hot word stream and reports the
//               bit position, per-word corruption pulses and an error count.
// Revision    : 1.0 - initial release
// ============================================================================
module rotabit_checker #(
  parameter int WIDTH      = 16,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_LIMIT  = 3,
  parameter int CNT_W      = 8,
  parameter bit ROT_LEFT   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         x,
  output logic                     locked,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     err,
  output logic [CNT_W-1:0]         err_count
);

  localparam int PW   = $clog2(WIDTH);
  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int ME_W = $clog2(ERR_LIMIT + 1);

  localparam logic [MC_W-1:0] c_lock_cnt = MC_W'(LOCK_COUNT);
  localparam logic [ME_W-1:0] c_err_lim  = ME_W'(ERR_LIMIT);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_CONFIRM = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_expected, w_exp_nxt;
  logic [MC_W-1:0]   r_match_cnt, w_match_nxt, w_match_inc;
  logic [ME_W-1:0]   r_miss_cnt, w_miss_nxt, w_miss_inc;
  logic              w_locked_nxt, w_err_nxt;
  logic [PW-1:0]     w_pos_nxt, w_x_idx, w_exp_idx;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [WIDTH-1:0]  w_next_x, w_next_exp;
  logic              w_x_onehot, w_x_match;

  function automatic logic [PW-1:0] f_index(input logic [WIDTH-1:0] v);
    f_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) f_index = PW'(i);
    end
  endfunction

  generate
    if (ROT_LEFT) begin : g_rot_left
      assign w_next_x   = {x[WIDTH-2:0], x[WIDTH-1]};
      assign w_next_exp = {r_expected[WIDTH-2:0], r_expected[WIDTH-1]};
    end else begin : g_rot_right
      assign w_next_x   = {x[0], x[WIDTH-1:1]};
      assign w_next_exp = {r_expected[0], r_expected[WIDTH-1:1]};
    end
  endgenerate

  // x & (x-1) clears the lowest set bit; zero result with x!=0 means one bit
  assign w_x_onehot  = (x != '0) && ((x & (x - WIDTH'(1))) == '0);
  assign w_x_match   = (x == r_expected);
  assign w_x_idx     = f_index(x);
  assign w_exp_idx   = f_index(r_expected);
  assign w_match_inc = r_match_cnt + MC_W'(1);
  assign w_miss_inc  = r_miss_cnt + ME_W'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_exp_nxt    = r_expected;
    w_match_nxt  = r_match_cnt;
    w_miss_nxt   = r_miss_cnt;
    w_locked_nxt = locked;
    w_pos_nxt    = pos;
    w_err_nxt    = 1'b0;
    w_cnt_nxt    = err_count;
    if (en) begin
      case (r_state)
        S_SEARCH: begin
          if (w_x_onehot) begin
            w_exp_nxt   = w_next_x;
            w_match_nxt = MC_W'(1);
            w_pos_nxt   = w_x_idx;
            w_state_nxt = S_CONFIRM;
          end
        end
        S_CONFIRM: begin
          if (w_x_match) begin
            w_exp_nxt   = w_next_x;
            w_pos_nxt   = w_x_idx;
            w_match_nxt = w_match_inc;
            if (w_match_inc == c_lock_cnt) begin
              w_state_nxt  = S_LOCKED;
              w_locked_nxt = 1'b1;
              w_miss_nxt   = '0;
            end
          end else if (w_x_onehot) begin
            w_exp_nxt   = w_next_x;
            w_pos_nxt   = w_x_idx;
            w_match_nxt = MC_W'(1);
          end else begin
            w_state_nxt = S_SEARCH;
            w_match_nxt = '0;
          end
        end
        S_LOCKED: begin
          if (w_x_match) begin
            w_exp_nxt  = w_next_x;
            w_pos_nxt  = w_x_idx;
            w_miss_nxt = '0;
          end else begin
            // flywheel: keep walking the expected word through the corruption
            w_err_nxt  = 1'b1;
            w_cnt_nxt  = (err_count == '1) ? err_count : err_count + CNT_W'(1);
            w_miss_nxt = w_miss_inc;
            w_exp_nxt  = w_next_exp;
            w_pos_nxt  = w_exp_idx;
            if (w_miss_inc == c_err_lim) begin
              w_state_nxt  = S_SEARCH;
              w_locked_nxt = 1'b0;
              w_match_nxt  = '0;
              w_miss_nxt   = '0;
            end
          end
        end
        default: w_state_nxt = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_SEARCH;
      r_expected  <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      locked      <= 1'b0;
      pos         <= '0;
      err         <= 1'b0;
      err_count   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_expected  <= w_exp_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
      locked      <= w_locked_nxt;
      pos         <= w_pos_nxt;
      err         <= w_err_nxt;
      err_count   <= w_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rotabit_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotabit_checker
// Description : Bench for rotabit_checker: three parameterisations checked
//               against a lock/run-length reference model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rotabit_checker;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] x;
  logic        lk_a, lk_b, lk_c, er_a, er_b, er_c;
  logic [3:0]  pos_a, pos_b, pos_c;
  logic [7:0]  cnt_a, cnt_b;
  logic [1:0]  cnt_c;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  rotabit_checker #(.WIDTH(16), .LOCK_COUNT(4), .ERR_LIMIT(3), .CNT_W(8), .ROT_LEFT(1'b1)) u_a (
    .clk(clk), .rst(rst), .en(en), .x(x), .locked(lk_a), .pos(pos_a), .err(er_a), .err_count(cnt_a));
  rotabit_checker #(.WIDTH(16), .LOCK_COUNT(4), .ERR_LIMIT(3), .CNT_W(8), .ROT_LEFT(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en), .x(x), .locked(lk_b), .pos(pos_b), .err(er_b), .err_count(cnt_b));
  rotabit_checker #(.WIDTH(16), .LOCK_COUNT(4), .ERR_LIMIT(8), .CNT_W(2), .ROT_LEFT(1'b1)) u_c (
    .clk(clk), .rst(rst), .en(en), .x(x), .locked(lk_c), .pos(pos_c), .err(er_c), .err_count(cnt_c));

  // Reference: unlocked behaviour is just a run length of correctly rotated words.
  typedef struct {
    bit locked;
    int run;
    int miss;
    int expw;
    int pos;
    bit err;
    int cnt;
  } mdl_t;

  mdl_t ma, mb, mc;

  function automatic bit is_onehot(int v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int nxt(int v, bit left);
    if (left) return ((v * 2) % 65536) + (v / 32768);
    else      return (v / 2) + ((v % 2) * 32768);
  endfunction

  function automatic mdl_t mreset();
    mdl_t n;
    n.locked = 0; n.run = 0; n.miss = 0; n.expw = 0; n.pos = 0; n.err = 0; n.cnt = 0;
    return n;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int xi, bit ev, bit left, int lc, int el, int cmax);
    mdl_t n = m;
    n.err = 0;
    if (!ev) return n;
    if (!m.locked) begin
      if (is_onehot(xi)) begin
        n.run  = (m.run > 0 && xi == m.expw) ? m.run + 1 : 1;
        n.expw = nxt(xi, left);
        n.pos  = $clog2(xi);
        if (n.run == lc) begin
          n.locked = 1;
          n.miss   = 0;
        end
      end else begin
        n.run = 0;
      end
    end else if (xi == m.expw) begin
      n.expw = nxt(xi, left);
      n.pos  = $clog2(xi);
      n.miss = 0;
    end else begin
      n.err  = 1;
      n.cnt  = (m.cnt < cmax) ? m.cnt + 1 : cmax;
      n.miss = m.miss + 1;
      n.pos  = $clog2(m.expw);
      n.expw = nxt(m.expw, left);
      if (n.miss == el) begin
        n.locked = 0;
        n.run    = 0;
        n.miss   = 0;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_dut(input string nm, input mdl_t m, input logic l, input logic [3:0] p,
                         input logic e, input logic [7:0] c);
    chk({nm, ".locked"}, {31'd0, l}, m.locked);
    chk({nm, ".pos"}, {28'd0, p}, m.pos);
    chk({nm, ".err"}, {31'd0, e}, m.err);
    chk({nm, ".err_count"}, {24'd0, c}, m.cnt);
  endtask

  task automatic cyc(input logic [15:0] xv, input logic ev);
    int xi;
    x  = xv;
    en = ev;
    xi = int'(xv);
    @(posedge clk);
    if (rst) begin
      ma = mreset(); mb = mreset(); mc = mreset();
    end else begin
      ma = mstep(ma, xi, ev, 1'b1, 4, 3, 255);
      mb = mstep(mb, xi, ev, 1'b0, 4, 3, 255);
      mc = mstep(mc, xi, ev, 1'b1, 4, 8, 3);
    end
    #1;
    chk_dut("A", ma, lk_a, pos_a, er_a, cnt_a);
    chk_dut("B", mb, lk_b, pos_b, er_b, cnt_b);
    chk_dut("C", mc, lk_c, pos_c, er_c, {6'd0, cnt_c});
  endtask

  initial begin
    logic [15:0] xv;
    int          w;
    bit          dir;
    bit          ev;
    int          r;

    // reset held while x toggles
    rst = 1'b1; en = 1'b1; x = 16'h0010;
    ma = mreset(); mb = mreset(); mc = mreset();
    #1;
    chk("rst.async.locked", {31'd0, lk_a}, 0);
    chk("rst.async.cnt", {24'd0, cnt_a}, 0);
    for (int i = 0; i < 4; i++) cyc((i % 2 == 0) ? 16'h0010 : 16'h0000, 1'b1);
    rst = 1'b0;
    cyc(16'h0000, 1'b1);

    // clean lock on walking-left words
    cyc(16'h0001, 1'b1);
    cyc(16'h0002, 1'b1);
    cyc(16'h0004, 1'b1);
    chk("lock.early", {31'd0, lk_a}, 0);
    cyc(16'h0008, 1'b1);
    chk("lock.locked", {31'd0, lk_a}, 1);
    chk("lock.pos", {28'd0, pos_a}, 3);

    // walk through the wrap point
    for (int i = 4; i < 16; i++) begin
      xv = 16'h0001 << i;
      cyc(xv, 1'b1);
    end
    chk("wrap.pos15", {28'd0, pos_a}, 15);
    cyc(16'h0001, 1'b1);
    chk("wrap.pos0", {28'd0, pos_a}, 0);
    chk("wrap.err", {31'd0, er_a}, 0);

    // single glitch
    cyc(16'h0002, 1'b1);
    cyc(16'h0004, 1'b1);
    cyc(16'h0008, 1'b1);
    cyc(16'h0010, 1'b1);
    cyc(16'h0030, 1'b1);
    chk("glitch.err", {31'd0, er_a}, 1);
    chk("glitch.pos", {28'd0, pos_a}, 5);
    chk("glitch.cnt", {24'd0, cnt_a}, 1);
    chk("glitch.locked", {31'd0, lk_a}, 1);
    cyc(16'h0040, 1'b1);
    chk("glitch.recover", {31'd0, er_a}, 0);

    // loss of lock after three consecutive misses
    cyc(16'h0000, 1'b1);
    cyc(16'h0000, 1'b1);
    chk("loss.still", {31'd0, lk_a}, 1);
    cyc(16'h0000, 1'b1);
    chk("loss.locked", {31'd0, lk_a}, 0);
    chk("loss.cnt", {24'd0, cnt_a}, 4);
    chk("sat.cnt", {30'd0, cnt_c}, 3);
    chk("sat.locked", {31'd0, lk_c}, 1);
    for (int i = 8; i < 12; i++) begin
      xv = 16'h0001 << i;
      cyc(xv, 1'b1);
    end
    chk("relock.locked", {31'd0, lk_a}, 1);
    chk("relock.cnt", {24'd0, cnt_a}, 4);
    chk("sat.hold", {30'd0, cnt_c}, 3);

    // rotate-right instance through its wrap point
    cyc(16'h0010, 1'b1);
    cyc(16'h0008, 1'b1);
    cyc(16'h0004, 1'b1);
    cyc(16'h0002, 1'b1);
    chk("right.locked", {31'd0, lk_b}, 1);
    chk("right.pos1", {28'd0, pos_b}, 1);
    cyc(16'h0001, 1'b1);
    chk("right.pos0", {28'd0, pos_b}, 0);
    cyc(16'h8000, 1'b1);
    chk("right.pos15", {28'd0, pos_b}, 15);
    chk("right.err", {31'd0, er_b}, 0);

    // stall with garbage
    for (int i = 0; i < 5; i++) begin
      xv = 16'($urandom);
      cyc(xv, 1'b0);
      chk("stall.err", {31'd0, er_b}, 0);
    end
    cyc(16'h4000, 1'b1);
    chk("stall.resume", {31'd0, er_b}, 0);
    chk("stall.pos", {28'd0, pos_b}, 14);
    chk("stall.locked", {31'd0, lk_b}, 1);

    // asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1;
    chk("arst.locked", {31'd0, lk_b}, 0);
    chk("arst.pos", {28'd0, pos_b}, 0);
    chk("arst.cnt", {24'd0, cnt_a}, 0);
    cyc(16'h0000, 1'b1);
    rst = 1'b0;

    // randomized walking streams with corruption and stalls
    w = 1; dir = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 0) dir = ~dir;
      ev = ($urandom_range(0, 9) != 0);
      r  = $urandom_range(0, 15);
      if (r < 12) begin
        xv = w[15:0];
        if (ev) w = nxt(w, dir);
      end else if (r == 12) begin
        xv = 16'($urandom);
      end else if (r == 13) begin
        xv = 16'h0000;
      end else begin
        xv = 16'h0001 << $urandom_range(0, 15);
      end
      cyc(xv, ev);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rotabit_checker.md
Name: rotabit_checker

Overview:
- Receive-side companion to the rotating one-hot pattern generator (rotabit).
- Samples the generator's 16-bit word every enabled clock and locks onto the walking-one sequence.
- While locked, reports the bit position, flags each corrupted word, and keeps a saturating error count.
- Sits directly on the generator output, on-board or in self-check benches, as a pattern integrity monitor.

Parameters:
- WIDTH, 16, pattern width; must be a power of two, >= 4.
- LOCK_COUNT, 4, consecutive correctly-rotated one-hot words required to enter lock (>= 2).
- ERR_LIMIT, 3, consecutive mismatches in lock that force loss of lock (>= 1).
- CNT_W, 8, width of the error counter.
- ROT_LEFT, 1, 1 = next word is rotate-left {x[W-2:0],x[W-1]}; 0 = rotate-right {x[0],x[W-1:1]}.

Ports:
- clk, in, 1, system clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- en, in, 1, sample enable; when 0 all state holds.
- x, in, WIDTH, pattern word from the generator.
- locked, out, 1, high while the FSM is in LOCKED.
- pos, out, log2(WIDTH), index of the set bit of the current expected/accepted word.
- err, out, 1, single-cycle pulse on a mismatch while LOCKED.
- err_count, out, CNT_W, saturating count of mismatches in LOCKED.

Behaviour:
- All outputs are registered. Sampling and updates occur on rising clk with en=1. Response latency is 1 edge.
- rst (async): state=SEARCH, expected=0, match_cnt=0, miss_cnt=0, locked=0, pos=0, err=0, err_count=0.
- onehot(x) means exactly one bit is set. x=0 is not one-hot. NEXT(v) is rotation per ROT_LEFT and wraps: bit W-1 -> bit 0 for left, bit 0 -> bit W-1 for right.
- SEARCH:
  - onehot(x): expected<=NEXT(x), match_cnt<=1, pos<=index(x), go CONFIRM.
  - Otherwise stay. No err.
- CONFIRM:
  - x==expected: expected<=NEXT(x), pos<=index(x), match_cnt++.
  - If the incremented count equals LOCK_COUNT: go LOCKED, locked<=1 on that same edge, miss_cnt<=0.
  - x!=expected and onehot(x): restart as a first word (match_cnt<=1, expected<=NEXT(x), pos<=index(x)); stay CONFIRM.
  - x!=expected and not one-hot: go SEARCH, match_cnt<=0.
  - No err pulses in CONFIRM.
- LOCKED:
  - x==expected: expected<=NEXT(x), pos<=index(x), miss_cnt<=0, err<=0.
  - x!=expected: err<=1 for one cycle, err_count<=err_count+1 (saturates at all-ones, no wrap), miss_cnt++.
  - On mismatch, flywheel: expected<=NEXT(expected), pos<=index(expected).
  - If the incremented miss_cnt equals ERR_LIMIT: go SEARCH, locked<=0, match_cnt<=0, miss_cnt<=0. This mismatch still pulses err and counts.
- en=0: err<=0. All other registers hold. Stalled cycles are not counted as mismatches.
- err_count clears only on rst. It holds across loss and regain of lock.
- Reset asserted mid-operation clears everything immediately, regardless of clk.

Test Plan:
- Reset: rst=1 with x=0x0010 toggling -> locked=0, pos=0, err=0, err_count=0 throughout; all hold reset values one edge after release with x=0.
- Clean lock: after rst, x=0x0001,0x0002,0x0004,0x0008 on successive edges -> locked rises on the 4th edge, pos=3. Continue the sequence -> err stays 0.
- Wrap-around: locked, feed 0x4000,0x8000,0x0001 -> no err, pos 14,15,0. With ROT_LEFT=0, feed 0x0002,0x0001,0x8000 -> no err, pos 1,0,15.
- Single glitch: locked at 0x0010, next word 0x0030 instead of 0x0020, then 0x0040 -> err pulses one cycle, err_count=1, pos=5 on the glitch edge, locked stays 1, miss_cnt clears on the 0x0040 match.
- Loss of lock: locked, feed 0x0000 three times -> err each edge, err_count=3, locked falls on the 3rd edge. Then 0x0100..0x0800 -> relock after 4 words, err_count still 3.
- Stall, saturation and mid-lock reset:
  - en=0 for 5 cycles with garbage x -> no err, state held.
  - CNT_W=2 with 5 mismatches (ERR_LIMIT large) -> err_count sticks at 3.
  - rst pulse while locked -> locked=0 before the next clk edge.
